// File: rtl/q6_fsm_pkg.sv
// Shared types and helpers for the six-state w-driven FSM and its driver.
// State codes match the receiver's y[3:1] encoding.
package q6_fsm_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CTL_IDLE  = 2'd0,
        CTL_DRIVE = 2'd1,
        CTL_FIN   = 2'd2
    } ctl_t;

    function automatic state_t next_state(input state_t s, input logic w);
        case (s)
            ST_A:    next_state = w ? ST_A : ST_B;
            ST_B:    next_state = w ? ST_D : ST_C;
            ST_C:    next_state = w ? ST_D : ST_E;
            ST_D:    next_state = w ? ST_A : ST_F;
            ST_E:    next_state = w ? ST_D : ST_E;
            ST_F:    next_state = w ? ST_D : ST_C;
            default: next_state = ST_A;
        endcase
    endfunction

    // First bit of a shortest path from cur to tgt.
    function automatic logic step_bit(input state_t cur, input state_t tgt);
        case (tgt)
            ST_A:       step_bit = 1'b1;
            ST_B:       step_bit = (cur != ST_A);
            ST_C:       step_bit = (cur == ST_E);
            ST_D, ST_F: step_bit = !((cur == ST_A) || (cur == ST_D));
            ST_E:       step_bit = 1'b0;
            default:    step_bit = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] code);
        is_legal = (code <= 3'd5);
    endfunction

    function automatic logic z_of(input state_t s);
        z_of = (s == ST_E) || (s == ST_F);
    endfunction

endpackage

// File: rtl/q6_fsm_model.sv
// Combinational receiver model: next state and its z output.
module q6_fsm_model
    import q6_fsm_pkg::*;
(
    input  state_t cur_i,
    input  logic   w_i,
    output state_t nxt_o,
    output logic   nz_o
);

    assign nxt_o = next_state(cur_i, w_i);
    assign nz_o  = z_of(nxt_o);

endmodule

// File: rtl/q6_seq_driver.sv
// Emits a shortest w bit stream steering the receiver FSM to a target,
// while tracking a shadow copy of the receiver state and z output.
module q6_seq_driver
    import q6_fsm_pkg::*;
#(
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_target,
    output logic             w,
    output logic             w_valid,
    input  logic             w_ready,
    output logic             done,
    output logic [LEN_W-1:0] done_len,
    output logic             err,
    output logic [2:0]       shadow_y,
    output logic             shadow_z
);

    ctl_t             ctl_q;
    state_t           tgt_q;
    state_t           shadow_q;
    logic             shadow_z_q;
    logic [LEN_W-1:0] len_q;
    logic             done_q;
    logic [LEN_W-1:0] done_len_q;
    logic             err_q;
    logic             w_d;
    state_t           nxt;
    logic             nz;
    logic [LEN_W-1:0] len_inc;

    always_comb begin
        w_d = 1'b0;
        if (ctl_q == CTL_DRIVE) begin
            w_d = step_bit(shadow_q, tgt_q);
        end
    end

    assign len_inc = len_q + LEN_W'(1);

    q6_fsm_model u_model (
        .cur_i (shadow_q),
        .w_i   (w_d),
        .nxt_o (nxt),
        .nz_o  (nz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q      <= CTL_IDLE;
            tgt_q      <= ST_A;
            shadow_q   <= ST_A;
            shadow_z_q <= 1'b0;
            len_q      <= '0;
            done_q     <= 1'b0;
            done_len_q <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_len_q <= '0;
            err_q      <= 1'b0;
            unique case (ctl_q)
                CTL_IDLE: begin
                    if (req_valid) begin
                        if (!is_legal(req_target)) begin
                            err_q <= 1'b1;
                        end else if (req_target == shadow_q) begin
                            len_q      <= '0;
                            done_q     <= 1'b1;
                            done_len_q <= '0;
                            ctl_q      <= CTL_FIN;
                        end else begin
                            tgt_q <= state_t'(req_target);
                            len_q <= '0;
                            ctl_q <= CTL_DRIVE;
                        end
                    end
                end
                CTL_DRIVE: begin
                    if (w_ready) begin
                        shadow_q   <= nxt;
                        shadow_z_q <= nz;
                        len_q      <= len_inc;
                        if (nxt == tgt_q) begin
                            done_q     <= 1'b1;
                            done_len_q <= len_inc;
                            ctl_q      <= CTL_FIN;
                        end
                    end
                end
                CTL_FIN: begin
                    ctl_q <= CTL_IDLE;
                end
                default: begin
                    ctl_q <= CTL_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (ctl_q == CTL_IDLE);
    assign w_valid   = (ctl_q == CTL_DRIVE);
    assign w         = w_d;
    assign done      = done_q;
    assign done_len  = done_len_q;
    assign err       = err_q;
    assign shadow_y  = shadow_q;
    assign shadow_z  = shadow_z_q;

endmodule

// File: tb/tb_q6_seq_driver.sv
// Self-checking bench for q6_seq_driver: request table plus reset corner cases.
module tb_q6_seq_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_target;
    logic       w;
    logic       w_valid;
    logic       w_ready;
    logic       done;
    logic [2:0] done_len;
    logic       err;
    logic [2:0] shadow_y;
    logic       shadow_z;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] tgt;
        int         stall;
        logic       exp_err;
        int         exp_len;
        logic [2:0] exp_bits;
        logic [2:0] exp_final;
    } vec_t;

    vec_t vecs[12];
    bit   bitq[$];
    int   lenq[$];

    always #5 clk = ~clk;

    q6_seq_driver #(.LEN_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .w          (w),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .done       (done),
        .done_len   (done_len),
        .err        (err),
        .shadow_y   (shadow_y),
        .shadow_z   (shadow_z)
    );

    // Independent receiver table: {w=1 next, w=0 next} per state.
    function automatic logic [2:0] ref_next(input logic [2:0] s, input logic b);
        logic [2:0] n0 [6];
        logic [2:0] n1 [6];
        n0 = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd4, 3'd2};
        n1 = '{3'd0, 3'd3, 3'd3, 3'd0, 3'd3, 3'd3};
        ref_next = b ? n1[s] : n0[s];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [2:0] start;
        logic [2:0] prev;
        logic       held_w;
        int         held;
        int         beats;
        bit         fin;
        bit         eb;
        start = shadow_y;
        chk($sformatf("v%0d req_ready", idx), int'(req_ready), 1);
        req_valid  = 1'b1;
        req_target = v.tgt;
        if (!v.exp_err) begin
            for (int i = 0; i < v.exp_len; i++) bitq.push_back(v.exp_bits[i]);
            lenq.push_back(v.exp_len);
        end
        tick();
        req_valid = 1'b0;
        if (v.exp_err) begin
            chk($sformatf("v%0d err", idx), int'(err), 1);
            chk($sformatf("v%0d err_wv", idx), int'(w_valid), 0);
            chk($sformatf("v%0d err_rdy", idx), int'(req_ready), 1);
            chk($sformatf("v%0d err_y", idx), int'(shadow_y), int'(start));
            tick();
            chk($sformatf("v%0d err_pulse", idx), int'(err), 0);
            return;
        end
        held   = 0;
        beats  = 0;
        fin    = 0;
        held_w = 1'b0;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            if (done) begin
                fin = 1;
            end else if (w_valid) begin
                eb = (bitq.size() > 0) ? bitq[0] : 1'b0;
                chk($sformatf("v%0d w%0d", idx, beats), int'(w), int'(eb));
                if (held > 0) chk($sformatf("v%0d hold", idx), int'(w), int'(held_w));
                held_w = w;
                if (held < v.stall) begin
                    w_ready = 1'b0;
                    held++;
                    tick();
                end else begin
                    w_ready = 1'b1;
                    prev    = shadow_y;
                    if (bitq.size() > 0) void'(bitq.pop_front());
                    tick();
                    w_ready = 1'b0;
                    held    = 0;
                    beats++;
                    chk($sformatf("v%0d y%0d", idx, beats), int'(shadow_y),
                        int'(ref_next(prev, eb)));
                    chk($sformatf("v%0d z%0d", idx, beats), int'(shadow_z),
                        int'(shadow_y >= 3'd4));
                end
            end else begin
                tick();
            end
        end
        chk($sformatf("v%0d done_seen", idx), int'(fin), 1);
        if (!fin) begin
            bitq.delete();
            lenq.delete();
            return;
        end
        chk($sformatf("v%0d done_len", idx), int'(done_len), lenq.pop_front());
        chk($sformatf("v%0d len_bound", idx), int'(done_len <= 3'd3), 1);
        chk($sformatf("v%0d beats", idx), beats, v.exp_len);
        chk($sformatf("v%0d bits_left", idx), bitq.size(), 0);
        chk($sformatf("v%0d final", idx), int'(shadow_y), int'(v.exp_final));
        chk($sformatf("v%0d fin_rdy", idx), int'(req_ready), 0);
        tick();
        chk($sformatf("v%0d done_pulse", idx), int'(done), 0);
        chk($sformatf("v%0d idle_rdy", idx), int'(req_ready), 1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_target = 3'd0;
        w_ready    = 1'b0;

        // {tgt, stall, err, len, bits (first in [0]), final}
        vecs[0]  = '{3'd4, 0, 1'b0, 3, 3'b000, 3'd4};
        vecs[1]  = '{3'd0, 0, 1'b0, 2, 3'b011, 3'd0};
        vecs[2]  = '{3'd0, 0, 1'b0, 0, 3'b000, 3'd0};
        vecs[3]  = '{3'd6, 0, 1'b1, 0, 3'b000, 3'd0};
        vecs[4]  = '{3'd1, 0, 1'b0, 1, 3'b000, 3'd1};
        vecs[5]  = '{3'd5, 2, 1'b0, 2, 3'b001, 3'd5};
        vecs[6]  = '{3'd2, 0, 1'b0, 1, 3'b000, 3'd2};
        vecs[7]  = '{3'd4, 1, 1'b0, 1, 3'b000, 3'd4};
        vecs[8]  = '{3'd2, 0, 1'b0, 3, 3'b001, 3'd2};
        vecs[9]  = '{3'd7, 0, 1'b1, 0, 3'b000, 3'd2};
        vecs[10] = '{3'd3, 0, 1'b0, 1, 3'b001, 3'd3};
        vecs[11] = '{3'd4, 0, 1'b0, 3, 3'b000, 3'd4};

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_y", int'(shadow_y), 0);
            chk("rst_z", int'(shadow_z), 0);
            chk("rst_rdy", int'(req_ready), 1);
            chk("rst_wv", int'(w_valid), 0);
            chk("rst_done", int'(done), 0);
        end
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset during a drive E->A after its first beat.
        req_valid  = 1'b1;
        req_target = 3'd0;
        tick();
        req_valid = 1'b0;
        chk("mr_wv", int'(w_valid), 1);
        chk("mr_w", int'(w), 1);
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        chk("mr_mid_y", int'(shadow_y), 3);
        chk("mr_mid_z", int'(shadow_z), 0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mr_y", int'(shadow_y), 0);
            chk("mr_done", int'(done), 0);
            chk("mr_wv", int'(w_valid), 0);
            chk("mr_rdy", int'(req_ready), 1);
        end
        reset = 1'b0;
        tick();
        chk("mr_post_done", int'(done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
